// File: rtl/galetron_pkg.sv
// Galetron boot sequencer shared types.
// State encoding, width defaults and fetch-mode constants.
package galetron_pkg;

    localparam int ADDR_W_DEF  = 10;
    localparam int DATA_W_DEF  = 32;
    localparam int DISK_AW_DEF = 16;
    localparam int TIMEOUT_DEF = 255;

    localparam logic MODE_BIOS = 1'b0;
    localparam logic MODE_PROG = 1'b1;

    typedef enum logic [2:0] {
        BIOS_RUN,
        COPY_REQ,
        COPY_WAIT,
        HANDOFF,
        PROG_RUN
    } boot_state_t;

endpackage

// File: rtl/boot_sequencer.sv
// Galetron boot sequencer: BIOS fetch, disk-to-imem copy, handoff.
// Owns the instruction-fetch mux and stalls the core during a copy.
module boot_sequencer
    import galetron_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DISK_AW = DISK_AW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [ADDR_W-1:0]  pc,
    output logic [DATA_W-1:0]  fetch_instr,
    output logic [ADDR_W-1:0]  bios_addr,
    input  logic [DATA_W-1:0]  bios_data,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [DATA_W-1:0]  imem_wdata,
    output logic               imem_we,
    input  logic [DATA_W-1:0]  imem_rdata,
    output logic [DISK_AW-1:0] disk_addr,
    output logic               disk_rd,
    input  logic [DATA_W-1:0]  disk_rdata,
    input  logic               disk_valid,
    input  logic               load_req,
    input  logic [DISK_AW-1:0] load_base,
    input  logic [ADDR_W:0]    load_len,
    input  logic               exit_req,
    output logic               stall,
    output logic               mode,
    output logic               done,
    output logic               err
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    boot_state_t          state;
    boot_state_t          state_nxt;
    logic [ADDR_W-1:0]    counter;
    logic [ADDR_W:0]      len_q;
    logic [DISK_AW-1:0]   base_q;
    logic [TIMER_W-1:0]   timer;
    logic                 last_word;
    logic                 timed_out;

    // Counter tops out at len-1, so the last write is detected by compare.
    assign last_word = ({1'b0, counter} == (len_q - (ADDR_W+1)'(1)));
    assign timed_out = (timer == TIMER_W'(TIMEOUT));

    assign bios_addr   = pc;
    assign imem_wdata  = disk_rdata;
    assign disk_addr   = base_q + DISK_AW'(counter);
    assign fetch_instr = (mode == MODE_PROG) ? imem_rdata : bios_data;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= BIOS_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a load beats a simultaneous exit in BIOS_RUN.
    always_comb begin
        state_nxt = state;
        unique case (state)
            BIOS_RUN: begin
                if (load_req) begin
                    state_nxt = (load_len == '0) ? HANDOFF : COPY_REQ;
                end
            end
            COPY_REQ: state_nxt = COPY_WAIT;
            COPY_WAIT: begin
                if (disk_valid) begin
                    state_nxt = last_word ? HANDOFF : COPY_REQ;
                end else if (timed_out) begin
                    state_nxt = BIOS_RUN;
                end
            end
            HANDOFF: state_nxt = PROG_RUN;
            PROG_RUN: begin
                if (exit_req) begin
                    state_nxt = BIOS_RUN;
                end
            end
            default: state_nxt = BIOS_RUN;
        endcase
    end

    // Moore/Mealy outputs; strobes vanish as soon as reset clears state.
    always_comb begin
        stall     = 1'b0;
        imem_we   = 1'b0;
        disk_rd   = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        mode      = MODE_BIOS;
        imem_addr = pc;
        unique case (state)
            COPY_REQ: begin
                stall     = 1'b1;
                disk_rd   = 1'b1;
                imem_addr = counter;
            end
            COPY_WAIT: begin
                stall     = 1'b1;
                imem_addr = counter;
                imem_we   = disk_valid;
                err       = !disk_valid && timed_out;
            end
            HANDOFF: begin
                stall = 1'b1;
                done  = 1'b1;
            end
            PROG_RUN: mode = MODE_PROG;
            default: ;
        endcase
    end

    // Copy datapath: latched image descriptor, word counter, wait timer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            base_q  <= '0;
            len_q   <= '0;
            counter <= '0;
            timer   <= '0;
        end else begin
            if (state == BIOS_RUN && load_req && load_len != '0) begin
                base_q  <= load_base;
                len_q   <= load_len;
                counter <= '0;
            end
            if (state == COPY_REQ) begin
                timer <= '0;
            end
            if (state == COPY_WAIT) begin
                timer <= timer + 1'b1;
                if (disk_valid) begin
                    counter <= last_word ? '0 : counter + 1'b1;
                end
            end
        end
    end

endmodule
